// File: rtl/game_state_keeper.sv
// game_state_keeper
//
// Owns the game-level state of the PACMAN design: score, remaining lives and
// remaining coins, plus the IDLE/PLAY/DYING/OVER/WIN state machine. It consumes
// the per-frame event pulses from the hit manager and the player start key. It
// drives restart/respawn pulses and a motion-freeze level back to the pacman,
// monster and coin-matrix blocks.
//
// Ports:
//   clk           in   pixel clock
//   resetN        in   asynchronous active-low reset
//   startOfFrame  in   one-cycle pulse per frame
//   startKey      in   start key level, synchronous to clk
//   coinTaken     in   one-cycle pulse when pacman eats a coin
//   monsterHit    in   one-cycle pulse when a monster catches pacman
//   gameState     out  0=IDLE 1=PLAY 2=DYING 3=OVER 4=WIN
//   score         out  saturating score
//   lives         out  remaining lives
//   coinsLeft     out  coins remaining on the board
//   freezeMotion  out  high whenever the game is not in PLAY
//   restartPulse  out  one cycle: refill coins, home all objects
//   respawnPulse  out  one cycle: home pacman and monsters, keep coins
module game_state_keeper #(
    parameter int TOTAL_COINS  = 150,
    parameter int START_LIVES  = 3,
    parameter int COIN_POINTS  = 10,
    parameter int DEATH_FRAMES = 60
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        startKey,
    input  logic        coinTaken,
    input  logic        monsterHit,
    output logic [2:0]  gameState,
    output logic [15:0] score,
    output logic [2:0]  lives,
    output logic [7:0]  coinsLeft,
    output logic        freezeMotion,
    output logic        restartPulse,
    output logic        respawnPulse
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_DYING = 3'd2,
        ST_OVER  = 3'd3,
        ST_WIN   = 3'd4
    } state_t;

    localparam int              FW          = $clog2(DEATH_FRAMES + 1);
    localparam logic [FW-1:0]   DEATH_LOAD  = FW'(DEATH_FRAMES);
    localparam logic [FW-1:0]   FRAME_ONE   = FW'(1);
    localparam logic [FW-1:0]   FRAME_ZERO  = FW'(0);
    localparam logic [7:0]      COINS_LOAD  = 8'(TOTAL_COINS);
    localparam logic [2:0]      LIVES_LOAD  = 3'(START_LIVES);
    localparam logic [16:0]     POINTS_EXT  = 17'(COIN_POINTS);

    state_t         state_r,   state_s;
    logic [15:0]    score_r,   score_s;
    logic [2:0]     lives_r,   lives_s;
    logic [7:0]     coins_r,   coins_s;
    logic [FW-1:0]  frame_r,   frame_s;
    logic           key_d_r;
    logic           freeze_r,  freeze_s;
    logic           restart_r, restart_s;
    logic           respawn_r, respawn_s;

    logic           key_edge_s;
    logic [16:0]    score_sum_s;
    logic [15:0]    score_inc_s;

    // Next-state, counter updates and pulse generation for the game FSM.
    always_comb begin
        state_s     = state_r;
        score_s     = score_r;
        lives_s     = lives_r;
        coins_s     = coins_r;
        frame_s     = frame_r;
        restart_s   = 1'b0;
        respawn_s   = 1'b0;
        key_edge_s  = startKey & ~key_d_r;
        // One extra bit catches the carry so the score sticks at all-ones.
        score_sum_s = {1'b0, score_r} + POINTS_EXT;
        if (score_sum_s[16]) begin
            score_inc_s = 16'hFFFF;
        end else begin
            score_inc_s = score_sum_s[15:0];
        end

        case (state_r)
            ST_IDLE, ST_OVER, ST_WIN: begin
                if (key_edge_s) begin
                    state_s   = ST_PLAY;
                    score_s   = 16'd0;
                    lives_s   = LIVES_LOAD;
                    coins_s   = COINS_LOAD;
                    restart_s = 1'b1;
                end else begin
                    state_s   = state_r;
                end
            end
            ST_PLAY: begin
                if (coinTaken) begin
                    score_s = score_inc_s;
                    if (coins_r != 8'd0) begin
                        coins_s = coins_r - 8'd1;
                    end else begin
                        coins_s = 8'd0;
                    end
                end else begin
                    coins_s = coins_r;
                end
                // The coin is applied first: eating the last coin wins even if
                // a monster touches pacman on the same cycle.
                if (coinTaken && (coins_r == 8'd1)) begin
                    state_s = ST_WIN;
                end else if (monsterHit) begin
                    if (lives_r != 3'd0) begin
                        lives_s = lives_r - 3'd1;
                    end else begin
                        lives_s = 3'd0;
                    end
                    frame_s = DEATH_LOAD;
                    state_s = ST_DYING;
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_DYING: begin
                if (startOfFrame) begin
                    // Treat a (never loaded) zero count like the last frame so
                    // DYING cannot get stuck.
                    if (frame_r <= FRAME_ONE) begin
                        frame_s = FRAME_ZERO;
                        if (lives_r == 3'd0) begin
                            state_s = ST_OVER;
                        end else begin
                            state_s   = ST_PLAY;
                            respawn_s = 1'b1;
                        end
                    end else begin
                        frame_s = frame_r - FRAME_ONE;
                    end
                end else begin
                    frame_s = frame_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        freeze_s = (state_s != ST_PLAY);
    end

    // State, counters, key history and all outputs, async-cleared by resetN.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r   <= ST_IDLE;
            score_r   <= 16'd0;
            lives_r   <= LIVES_LOAD;
            coins_r   <= COINS_LOAD;
            frame_r   <= FRAME_ZERO;
            key_d_r   <= 1'b0;
            freeze_r  <= 1'b1;
            restart_r <= 1'b0;
            respawn_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            score_r   <= score_s;
            lives_r   <= lives_s;
            coins_r   <= coins_s;
            frame_r   <= frame_s;
            key_d_r   <= startKey;
            freeze_r  <= freeze_s;
            restart_r <= restart_s;
            respawn_r <= respawn_s;
        end
    end

    assign gameState    = state_r;
    assign score        = score_r;
    assign lives        = lives_r;
    assign coinsLeft    = coins_r;
    assign freezeMotion = freeze_r;
    assign restartPulse = restart_r;
    assign respawnPulse = respawn_r;

endmodule

// File: tb/tb_game_state_keeper.sv
// Bench for game_state_keeper. Three instances: default parameters (A), a
// two-coin board (B) and a 255-coin / 300-point board with a short death time
// (C) used to reach score saturation. Stimulus pushes hand-computed expected
// snapshots tagged with the cycle they apply to; a negedge monitor pops and
// compares them.
module tb_game_state_keeper;

    logic clk;
    logic resetN;
    logic sof;
    logic key  [3];
    logic coin [3];
    logic hit  [3];

    logic [2:0]  gs [3];
    logic [15:0] sc [3];
    logic [2:0]  lv [3];
    logic [7:0]  cl [3];
    logic        fz [3];
    logic        rs [3];
    logic        rp [3];

    int cyc;
    int vectors;
    int miscompares;

    typedef struct {
        int          cyc;
        int          d;
        logic [2:0]  g;
        logic [15:0] s;
        logic [2:0]  l;
        logic [7:0]  c;
        logic        f;
        logic        r;
        logic        p;
        string       nm;
    } exp_t;

    exp_t q[$];
    exp_t e_m;

    game_state_keeper u_a (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .startKey(key[0]),
        .coinTaken(coin[0]), .monsterHit(hit[0]), .gameState(gs[0]),
        .score(sc[0]), .lives(lv[0]), .coinsLeft(cl[0]), .freezeMotion(fz[0]),
        .restartPulse(rs[0]), .respawnPulse(rp[0])
    );

    game_state_keeper #(.TOTAL_COINS(2)) u_b (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .startKey(key[1]),
        .coinTaken(coin[1]), .monsterHit(hit[1]), .gameState(gs[1]),
        .score(sc[1]), .lives(lv[1]), .coinsLeft(cl[1]), .freezeMotion(fz[1]),
        .restartPulse(rs[1]), .respawnPulse(rp[1])
    );

    game_state_keeper #(.TOTAL_COINS(255), .COIN_POINTS(300), .DEATH_FRAMES(2)) u_c (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .startKey(key[2]),
        .coinTaken(coin[2]), .monsterHit(hit[2]), .gameState(gs[2]),
        .score(sc[2]), .lives(lv[2]), .coinsLeft(cl[2]), .freezeMotion(fz[2]),
        .restartPulse(rs[2]), .respawnPulse(rp[2])
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index, advanced at each active edge.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due at this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e_m = q.pop_front();
            vectors++;
            if (e_m.cyc != cyc) begin
                miscompares++;
                $display("FAIL %s: expectation for cycle %0d checked late at cycle %0d",
                         e_m.nm, e_m.cyc, cyc);
            end else if ({gs[e_m.d], sc[e_m.d], lv[e_m.d], cl[e_m.d], fz[e_m.d], rs[e_m.d], rp[e_m.d]} !==
                         {e_m.g, e_m.s, e_m.l, e_m.c, e_m.f, e_m.r, e_m.p}) begin
                miscompares++;
                $display("FAIL %s (dut %0d, cycle %0d): got gs=%0d sc=%0d lv=%0d cl=%0d fz=%0b rs=%0b rp=%0b, want gs=%0d sc=%0d lv=%0d cl=%0d fz=%0b rs=%0b rp=%0b",
                         e_m.nm, e_m.d, cyc,
                         gs[e_m.d], sc[e_m.d], lv[e_m.d], cl[e_m.d], fz[e_m.d], rs[e_m.d], rp[e_m.d],
                         e_m.g, e_m.s, e_m.l, e_m.c, e_m.f, e_m.r, e_m.p);
            end
        end
    end

    // Watchdog: the run must end on its own.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push an expected snapshot for cycle (cyc + off) of instance d.
    task automatic ex(input int d, input int off, input string nm, input int g,
                      input int s, input int l, input int c, input int f,
                      input int r, input int p);
        exp_t e;
        e.cyc = cyc + off;
        e.d   = d;
        e.g   = 3'(g);
        e.s   = 16'(s);
        e.l   = 3'(l);
        e.c   = 8'(c);
        e.f   = 1'(f);
        e.r   = 1'(r);
        e.p   = 1'(p);
        e.nm  = nm;
        q.push_back(e);
    endtask

    // Instance A: monster hit, a coin ignored while dying, then 60 frames.
    task automatic die_a(input int lv_after, input int s, input int c);
        hit[0] = 1'b1; tick(); hit[0] = 1'b0;
        ex(0, 0, "hit", 2, s, lv_after, c, 1, 0, 0);
        coin[0] = 1'b1; tick(); coin[0] = 1'b0;
        ex(0, 0, "coin_in_dying", 2, s, lv_after, c, 1, 0, 0);
        sof = 1'b1;
        for (int i = 0; i < 59; i++) begin
            tick();
            ex(0, 0, "dying_hold", 2, s, lv_after, c, 1, 0, 0);
        end
        tick();
        sof = 1'b0;
        if (lv_after == 0) begin
            ex(0, 0, "game_over", 3, s, 0, c, 1, 0, 0);
            ex(0, 1, "game_over_hold", 3, s, 0, c, 1, 0, 0);
        end else begin
            ex(0, 0, "respawn", 1, s, lv_after, c, 0, 0, 1);
            ex(0, 1, "respawn_end", 1, s, lv_after, c, 0, 0, 0);
        end
        tick();
    endtask

    initial begin
        int sx;
        vectors     = 0;
        miscompares = 0;
        resetN      = 1'b0;
        sof         = 1'b0;
        for (int i = 0; i < 3; i++) begin
            key[i]  = 1'b0;
            coin[i] = 1'b0;
            hit[i]  = 1'b0;
        end

        // Reset values.
        tick(); tick(); tick();
        ex(0, 0, "reset_a", 0, 0, 3, 150, 1, 0, 0);
        ex(1, 0, "reset_b", 0, 0, 3, 2, 1, 0, 0);
        ex(2, 0, "reset_c", 0, 0, 3, 255, 1, 0, 0);
        tick();
        resetN = 1'b1;
        tick();
        ex(0, 0, "idle_after_reset", 0, 0, 3, 150, 1, 0, 0);

        // Start key edge.
        key[0] = 1'b1; tick(); key[0] = 1'b0;
        ex(0, 0, "start", 1, 0, 3, 150, 0, 1, 0);
        ex(0, 1, "start_pulse_end", 1, 0, 3, 150, 0, 0, 0);
        tick();

        // Three coins.
        for (int k = 1; k <= 3; k++) begin
            coin[0] = 1'b1; tick(); coin[0] = 1'b0;
            ex(0, 0, "coin", 1, 10 * k, 3, 150 - k, 0, 0, 0);
            tick();
        end

        // Key held: no restart while playing.
        key[0] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            ex(0, 0, "key_held", 1, 30, 3, 147, 0, 0, 0);
        end
        key[0] = 1'b0;
        tick();

        // Three deaths: respawn, respawn, game over.
        die_a(2, 30, 147);
        die_a(1, 30, 147);
        die_a(0, 30, 147);

        // Restart from OVER.
        key[0] = 1'b1; tick(); key[0] = 1'b0;
        ex(0, 0, "restart_over", 1, 0, 3, 150, 0, 1, 0);
        ex(0, 1, "restart_over_end", 1, 0, 3, 150, 0, 0, 0);
        tick();

        // Two-coin board: last coin with simultaneous hit wins.
        key[1] = 1'b1; tick(); key[1] = 1'b0;
        ex(1, 0, "b_start", 1, 0, 3, 2, 0, 1, 0);
        coin[1] = 1'b1; tick(); coin[1] = 1'b0;
        ex(1, 0, "b_coin1", 1, 10, 3, 1, 0, 0, 0);
        coin[1] = 1'b1; hit[1] = 1'b1; tick(); coin[1] = 1'b0; hit[1] = 1'b0;
        ex(1, 0, "b_win", 4, 20, 3, 0, 1, 0, 0);
        coin[1] = 1'b1; tick(); coin[1] = 1'b0;
        ex(1, 0, "b_win_hold", 4, 20, 3, 0, 1, 0, 0);
        key[1] = 1'b1; tick(); key[1] = 1'b0;
        ex(1, 0, "b_restart", 1, 0, 3, 2, 0, 1, 0);
        coin[1] = 1'b1; hit[1] = 1'b1; tick(); coin[1] = 1'b0; hit[1] = 1'b0;
        ex(1, 0, "b_coin_and_hit", 2, 10, 2, 1, 1, 0, 0);
        tick();

        // Saturation board: 300 points per coin crosses 0xFFFF at coin 219.
        key[2] = 1'b1; tick(); key[2] = 1'b0;
        ex(2, 0, "c_start", 1, 0, 3, 255, 0, 1, 0);
        for (int k = 1; k <= 220; k++) begin
            coin[2] = 1'b1; tick(); coin[2] = 1'b0;
            sx = (300 * k > 65535) ? 65535 : 300 * k;
            ex(2, 0, "c_sat", 1, sx, 3, 255 - k, 0, 0, 0);
        end
        // Frame pulse on the hit cycle is not counted; two more are.
        hit[2] = 1'b1; sof = 1'b1; tick(); hit[2] = 1'b0; sof = 1'b0;
        ex(2, 0, "c_hit_sof", 2, 65535, 2, 35, 1, 0, 0);
        sof = 1'b1; tick(); sof = 1'b0;
        ex(2, 0, "c_dying_1", 2, 65535, 2, 35, 1, 0, 0);
        sof = 1'b1; tick(); sof = 1'b0;
        ex(2, 0, "c_respawn", 1, 65535, 2, 35, 0, 0, 1);
        tick();

        // Asynchronous reset in the middle of DYING.
        coin[0] = 1'b1; tick(); coin[0] = 1'b0;
        ex(0, 0, "pre_reset_coin", 1, 10, 3, 149, 0, 0, 0);
        hit[0] = 1'b1; tick(); hit[0] = 1'b0;
        ex(0, 0, "pre_reset_hit", 2, 10, 2, 149, 1, 0, 0);
        sof = 1'b1; tick(); sof = 1'b0;
        resetN = 1'b0;
        ex(0, 0, "async_reset", 0, 0, 3, 150, 1, 0, 0);
        tick(); tick();
        resetN = 1'b1;
        tick();
        ex(0, 0, "post_reset", 0, 0, 3, 150, 1, 0, 0);
        ex(0, 1, "post_reset_hold", 0, 0, 3, 150, 1, 0, 0);
        tick();

        // Drain outstanding expectations within a bounded number of cycles.
        for (int i = 0; i < 20 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            $display("FAIL drain: %0d expectations never checked", q.size());
            miscompares += q.size();
        end
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
